grdes_multistart_ctrl: RTL and testbench
========================================

// Module: grdes_multistart_ctrl
// PURPOSE
//  Upstream sequencer for the GrDes gradient-descent core. Sweeps NUM_STARTS initial points
//  (a=b=c=d=seed, seed += INCREMENT per start), runs the core once per point, and tracks the
//  global minimum z across all runs. Replaces the bench-driven start/reset loop with synthesizable control.
// PARAMETERS
//  NUM_STARTS      49            number of core runs per sweep (0 allowed)
//  START_VALUE     8'sh00        first seed, signed 8-bit integer
//  INCREMENT       8'sh01        seed step, signed 8-bit, two's-complement wrap
//  TIMEOUT_CYCLES  4096          max cycles waiting for core_done before the run is abandoned
//  CLEAR_CYCLES    2             cycles core_rst_n is held low between runs (>=1)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  sweep_start  in   1   level/pulse; sampled in IDLE only
//  core_a_init..core_d_init  out  8 (each)  signed seed to core a/b/c/d_initial; registered
//  core_start   out  1   to core start_op
//  core_rst_n   out  1   to core rst_n (active-low core clear)
//  core_done    in   1   from core done_op
//  core_z_min   in   32  signed Q24.8 from core z_min
//  core_a_min..core_d_min  in  8 (each)  signed from core final_*_at_min
//  best_z       out  32  signed Q24.8 lowest z seen this sweep
//  best_a..best_d  out  8 (each)  signed coordinates at best_z
//  best_index   out  IDX_W=$clog2(NUM_STARTS+1)  run number (0-based) that produced best_z
//  best_valid   out  1   at least one run captured this sweep
//  timeout_err  out  1   sticky: some run hit TIMEOUT_CYCLES this sweep
//  sweep_busy   out  1   high from leaving IDLE until FINISH
//  sweep_done   out  1   one-cycle pulse at sweep end
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, core_start=0, core_rst_n=0, seeds=START_VALUE,
//   best_z=32'sh7FFF_FFFF, best_a..d=0, best_index=0, best_valid=0, timeout_err=0, busy=0, done=0.
//  FSM: IDLE -> ARM -> WAIT_DONE -> CAPTURE -> CLEAR -> WAIT_LOW -> (ARM | FINISH) -> IDLE.
//  IDLE: core_rst_n=0. On sweep_start: clear best_*/timeout_err, seed=START_VALUE, run=0;
//   NUM_STARTS==0 -> FINISH directly (best_valid stays 0).
//  ARM (1 cycle): core_rst_n=1; core_start=1 from this cycle; seeds already stable since prior cycle.
//  WAIT_DONE: core_start held 1; timer counts. core_done=1 -> CAPTURE. Timer reaches
//   TIMEOUT_CYCLES-1 without done -> set timeout_err, skip CAPTURE, go CLEAR.
//  CAPTURE (1 cycle): if !best_valid or core_z_min < best_z (signed, strict) load best_* from core
//   outputs, best_index=run, best_valid=1. Ties keep the earlier run.
//  CLEAR: core_start=0, core_rst_n=0 for CLEAR_CYCLES cycles.
//  WAIT_LOW: core_rst_n stays 0 until core_done==0; then seed+=INCREMENT (8-bit wrap, 127+1=-128),
//   run+=1; run==NUM_STARTS -> FINISH else ARM.
//  FINISH (1 cycle): sweep_done=1, busy=0 next cycle; best_* held until next sweep_start.
//  sweep_start while busy: ignored. core_done high outside WAIT_DONE: ignored.
//  core_done and timeout on same cycle: done wins (capture, no error).
//  Latency per run, ideal core: 1 (ARM) + core latency + 1 (CAPTURE) + CLEAR_CYCLES + 1 (WAIT_LOW).
// STRUCTURE
//  Shared package grdes_pkg: FSM state enum, Q24.8 Q_MAX constant (32'sh7FFF_FFFF), seed/coord width (8).
//  One sub-module: grdes_min_tracker (best_* registers + signed compare, capture/clear strobes).
//  Timer and run counter stay in the top FSM.
// TESTING
//  Bench uses a behavioural core: done after L cycles, z = f(seed) from a table.
//  1 NUM_STARTS=4, seeds 0..3, z={5.0,2.0,3.0,2.0} -> best_z=0x200, best_index=1, best_a=1, sweep_done once.
//  2 START_VALUE=126, INCREMENT=1, NUM_STARTS=4 -> core sees seeds 126,127,-128,-127 in order.
//  3 Core never asserts done on run 2, TIMEOUT_CYCLES=16 -> timeout_err=1, run 2 skipped, sweep completes.
//  4 rst pulsed mid WAIT_DONE -> same cycle core_start=0, core_rst_n=0, best_valid=0, busy=0.
//  5 NUM_STARTS=0, sweep_start -> sweep_done pulse 2 cycles later, best_valid=0, core_start never 1.
//  6 sweep_start re-pulsed while busy; core_done stuck high in WAIT_LOW -> both ignored/stalled, no extra run.

Source files
------------

// File: rtl/grdes_pkg.sv
// Shared types and constants for the GrDes multistart sequencer.
package grdes_pkg;

  localparam int COORD_W = 8;
  localparam int Q_W     = 32;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [Q_W-1:0]     qval_t;

  localparam qval_t Q_MAX = 32'sh7FFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_CLEAR     = 3'd4,
    ST_WAIT_LOW  = 3'd5,
    ST_FINISH    = 3'd6
  } state_e;

endpackage

// File: rtl/grdes_min_tracker.sv
// Holds the best (lowest z) result of a sweep; strict signed compare so ties keep the earlier run.
module grdes_min_tracker
  import grdes_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             capture,
  input  qval_t            z,
  input  coord_t           a,
  input  coord_t           b,
  input  coord_t           c,
  input  coord_t           d,
  input  logic [IDX_W-1:0] index,
  output qval_t            best_z,
  output coord_t           best_a,
  output coord_t           best_b,
  output coord_t           best_c,
  output coord_t           best_d,
  output logic [IDX_W-1:0] best_index,
  output logic             best_valid
);

  logic take;

  assign take = capture && (!best_valid || (z < best_z));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_z     <= Q_MAX;
      best_a     <= '0;
      best_b     <= '0;
      best_c     <= '0;
      best_d     <= '0;
      best_index <= '0;
      best_valid <= 1'b0;
    end else if (clear) begin
      best_z     <= Q_MAX;
      best_a     <= '0;
      best_b     <= '0;
      best_c     <= '0;
      best_d     <= '0;
      best_index <= '0;
      best_valid <= 1'b0;
    end else if (take) begin
      best_z     <= z;
      best_a     <= a;
      best_b     <= b;
      best_c     <= c;
      best_d     <= d;
      best_index <= index;
      best_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/grdes_multistart_ctrl.sv
// Sweeps NUM_STARTS seeds through the GrDes core, one run per seed, and tracks the global minimum.
module grdes_multistart_ctrl
  import grdes_pkg::*;
#(
  parameter int                  NUM_STARTS     = 49,
  parameter logic signed [7:0]   START_VALUE    = 8'sh00,
  parameter logic signed [7:0]   INCREMENT      = 8'sh01,
  parameter int                  TIMEOUT_CYCLES = 4096,
  parameter int                  CLEAR_CYCLES   = 2,
  localparam int                 IDX_W          = (NUM_STARTS > 0) ? $clog2(NUM_STARTS + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sweep_start,
  output coord_t           core_a_init,
  output coord_t           core_b_init,
  output coord_t           core_c_init,
  output coord_t           core_d_init,
  output logic             core_start,
  output logic             core_rst_n,
  input  logic             core_done,
  input  qval_t            core_z_min,
  input  coord_t           core_a_min,
  input  coord_t           core_b_min,
  input  coord_t           core_c_min,
  input  coord_t           core_d_min,
  output qval_t            best_z,
  output coord_t           best_a,
  output coord_t           best_b,
  output coord_t           best_c,
  output coord_t           best_d,
  output logic [IDX_W-1:0] best_index,
  output logic             best_valid,
  output logic             timeout_err,
  output logic             sweep_busy,
  output logic             sweep_done,
  output state_e           fsm_state
);

  localparam int TMAX = (TIMEOUT_CYCLES > CLEAR_CYCLES) ? TIMEOUT_CYCLES : CLEAR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  state_e           state;
  state_e           next;
  logic [TW-1:0]    timer;
  logic [IDX_W-1:0] run;
  coord_t           seed;
  logic             timer_expired;
  logic             clear_expired;
  logic             run_last;
  logic             sweep_go;
  logic             capture;

  assign timer_expired = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign clear_expired = (timer == TW'(CLEAR_CYCLES - 1));
  assign run_last      = (32'(run) == NUM_STARTS - 1);
  assign sweep_go      = (state == ST_IDLE) && sweep_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      ST_IDLE:      if (sweep_start) next = (NUM_STARTS == 0) ? ST_FINISH : ST_ARM;
      ST_ARM:       next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        // done wins over a timeout landing on the same cycle
        if (core_done)          next = ST_CAPTURE;
        else if (timer_expired) next = ST_CLEAR;
      end
      ST_CAPTURE:   next = ST_CLEAR;
      ST_CLEAR:     if (clear_expired) next = ST_WAIT_LOW;
      ST_WAIT_LOW:  if (!core_done) next = run_last ? ST_FINISH : ST_ARM;
      ST_FINISH:    next = ST_IDLE;
      default:      next = ST_IDLE;
    endcase
  end

  // Core handshake: core_start is a level held from ARM through CAPTURE; core_done is only
  // honoured in WAIT_DONE, and must drop (core held in clear) before the next run is armed.
  always_comb begin
    core_start = 1'b0;
    core_rst_n = 1'b0;
    sweep_busy = 1'b1;
    sweep_done = 1'b0;
    capture    = 1'b0;
    unique case (state)
      ST_IDLE:      sweep_busy = 1'b0;
      ST_ARM,
      ST_WAIT_DONE: begin
        core_start = 1'b1;
        core_rst_n = 1'b1;
      end
      ST_CAPTURE:   begin
        core_start = 1'b1;
        core_rst_n = 1'b1;
        capture    = 1'b1;
      end
      ST_FINISH:    sweep_done = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer       <= '0;
      run         <= '0;
      seed        <= START_VALUE;
      timeout_err <= 1'b0;
    end else begin
      if (state != next)
        timer <= '0;
      else if (state == ST_WAIT_DONE || state == ST_CLEAR)
        timer <= timer + TW'(1);

      if (sweep_go) begin
        run         <= '0;
        seed        <= START_VALUE;
        timeout_err <= 1'b0;
      end else if (state == ST_WAIT_DONE && !core_done && timer_expired) begin
        timeout_err <= 1'b1;
      end else if (state == ST_WAIT_LOW && !core_done) begin
        run  <= run + IDX_W'(1);
        seed <= seed + INCREMENT;
      end
    end
  end

  assign core_a_init = seed;
  assign core_b_init = seed;
  assign core_c_init = seed;
  assign core_d_init = seed;
  assign fsm_state   = state;

  grdes_min_tracker #(.IDX_W(IDX_W)) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear      (sweep_go),
    .capture    (capture),
    .z          (core_z_min),
    .a          (core_a_min),
    .b          (core_b_min),
    .c          (core_c_min),
    .d          (core_d_min),
    .index      (run),
    .best_z     (best_z),
    .best_a     (best_a),
    .best_b     (best_b),
    .best_c     (best_c),
    .best_d     (best_d),
    .best_index (best_index),
    .best_valid (best_valid)
  );

endmodule

// File: tb/tb_grdes_multistart_ctrl.sv
// Bench for grdes_multistart_ctrl: behavioural cores, seed and sweep-result scoreboards.
module tb_grdes_multistart_ctrl;
  import grdes_pkg::*;

  localparam int LAT = 3;
  localparam int W   = 69;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-instance signals (0: START 0, 1: START 126)
  logic       sweep_start [2];
  logic       force_done  [2];
  logic       hang_en     [2];
  logic [7:0] hang_seed   [2];
  state_e     fsm_state   [2];
  logic       core_start  [2];
  logic       core_rst_n  [2];
  logic       core_done   [2];
  logic [7:0] a_init [2], b_init [2], c_init [2], d_init [2];
  logic [31:0] best_z [2];
  logic [7:0] best_a [2], best_b [2], best_c [2], best_d [2];
  logic [2:0] best_index [2];
  logic       best_valid [2], timeout_err [2], sweep_busy [2], sweep_done [2];

  logic [W-1:0] exp_q [3][$];
  logic [7:0]   seed_q [2][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] z_of(input logic [7:0] s);
    case (s)
      8'h00:   z_of = 32'h0000_0500;
      8'h01:   z_of = 32'h0000_0200;
      8'h02:   z_of = 32'h0000_0300;
      8'h03:   z_of = 32'h0000_0200;
      8'h7E:   z_of = 32'h0000_0100;
      8'h7F:   z_of = 32'h0000_0080;
      8'h80:   z_of = 32'hFFFF_FF00;
      8'h81:   z_of = 32'hFFFF_FF00;
      default: z_of = 32'h0000_1000;
    endcase
  endfunction

  // Behavioural core coordinates at the minimum, derived from the seed
  function automatic logic [31:0] coords_of(input logic [7:0] s);
    logic [7:0] nb;
    nb = 8'h00 - s;
    coords_of = {s, s ^ 8'h55, ~s, nb};
  endfunction

  function automatic logic [W-1:0] exp_pack(input logic [31:0] z, input logic [31:0] abcd,
                                            input logic [2:0] idx, input logic v, input logic t);
    exp_pack = {z, abcd, idx, v, t};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam logic signed [7:0] SV = (g == 0) ? 8'sh00 : 8'sh7E;
    logic        mdone = 1'b0;
    int          cnt = 0;
    logic [31:0] mz = '0;
    logic [7:0]  ma = '0, mb = '0, mc = '0, md = '0;
    logic        prev_start = 1'b0;

    assign core_done[g] = mdone | force_done[g];

    grdes_multistart_ctrl #(
      .NUM_STARTS(4), .START_VALUE(SV), .INCREMENT(8'sh01),
      .TIMEOUT_CYCLES(16), .CLEAR_CYCLES(2)
    ) u_dut (
      .clk(clk), .rst(rst), .sweep_start(sweep_start[g]),
      .core_a_init(a_init[g]), .core_b_init(b_init[g]),
      .core_c_init(c_init[g]), .core_d_init(d_init[g]),
      .core_start(core_start[g]), .core_rst_n(core_rst_n[g]), .core_done(core_done[g]),
      .core_z_min(mz), .core_a_min(ma), .core_b_min(mb), .core_c_min(mc), .core_d_min(md),
      .best_z(best_z[g]), .best_a(best_a[g]), .best_b(best_b[g]),
      .best_c(best_c[g]), .best_d(best_d[g]), .best_index(best_index[g]),
      .best_valid(best_valid[g]), .timeout_err(timeout_err[g]),
      .sweep_busy(sweep_busy[g]), .sweep_done(sweep_done[g]), .fsm_state(fsm_state[g])
    );

    always @(posedge clk) begin
      if (!core_rst_n[g]) begin
        cnt   <= 0;
        mdone <= 1'b0;
      end else if (core_start[g] && !mdone && !(hang_en[g] && a_init[g] == hang_seed[g])) begin
        if (cnt == LAT - 1) begin
          mdone <= 1'b1;
          mz    <= z_of(a_init[g]);
          {ma, mb, mc, md} <= coords_of(a_init[g]);
        end
        cnt <= cnt + 1;
      end
    end

    // Seed monitor: every new run must present the next expected seed on all four inputs
    always @(negedge clk) begin
      logic [7:0] s;
      if (core_start[g] && !prev_start) begin
        if (seed_q[g].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL g%0d extra_run: got seed 0x%h expected no run", g, a_init[g]);
        end else begin
          s = seed_q[g].pop_front();
          check($sformatf("g%0d seed_a", g), {24'h0, a_init[g]}, {24'h0, s});
          check($sformatf("g%0d seed_bcd", g), {8'h0, b_init[g], c_init[g], d_init[g]}, {8'h0, s, s, s});
        end
      end
      prev_start = core_start[g];
    end

    // Result monitor
    always @(negedge clk) begin
      logic [W-1:0] e;
      if (sweep_done[g]) begin
        if (exp_q[g].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL g%0d extra_sweep_done: got pulse expected none", g);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("g%0d best_z", g), best_z[g], e[68:37]);
          check($sformatf("g%0d best_abcd", g), {best_a[g], best_b[g], best_c[g], best_d[g]}, e[36:5]);
          check($sformatf("g%0d best_index", g), {29'h0, best_index[g]}, {29'h0, e[4:2]});
          check($sformatf("g%0d best_valid", g), {31'h0, best_valid[g]}, {31'h0, e[1]});
          check($sformatf("g%0d timeout_err", g), {31'h0, timeout_err[g]}, {31'h0, e[0]});
        end
      end
    end
  end

  // Instance with NUM_STARTS=0: core never used
  logic        c_sweep_start = 1'b0;
  logic [7:0]  c_a, c_b, c_c, c_d, c_ba, c_bb, c_bc, c_bd;
  logic        c_core_start, c_core_rst_n, c_bidx, c_bvalid, c_terr, c_busy, c_done;
  logic [31:0] c_bz;
  state_e      c_state;
  logic        c_start_seen = 1'b0;

  grdes_multistart_ctrl #(
    .NUM_STARTS(0), .START_VALUE(8'sh00), .INCREMENT(8'sh01),
    .TIMEOUT_CYCLES(16), .CLEAR_CYCLES(2)
  ) u_dut_zero (
    .clk(clk), .rst(rst), .sweep_start(c_sweep_start),
    .core_a_init(c_a), .core_b_init(c_b), .core_c_init(c_c), .core_d_init(c_d),
    .core_start(c_core_start), .core_rst_n(c_core_rst_n), .core_done(1'b0),
    .core_z_min(32'sh0000_0100), .core_a_min(8'sh01), .core_b_min(8'sh02),
    .core_c_min(8'sh03), .core_d_min(8'sh04),
    .best_z(c_bz), .best_a(c_ba), .best_b(c_bb), .best_c(c_bc), .best_d(c_bd),
    .best_index(c_bidx), .best_valid(c_bvalid), .timeout_err(c_terr),
    .sweep_busy(c_busy), .sweep_done(c_done), .fsm_state(c_state)
  );

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (c_core_start) c_start_seen = 1'b1;
    if (c_done) begin
      if (exp_q[2].size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL zero extra_sweep_done: got pulse expected none");
      end else begin
        e = exp_q[2].pop_front();
        check("zero best_z", c_bz, e[68:37]);
        check("zero best_abcd", {c_ba, c_bb, c_bc, c_bd}, e[36:5]);
        check("zero best_valid", {31'h0, c_bvalid}, {31'h0, e[1]});
      end
    end
  end

  task automatic pulse_start(input int g);
    @(negedge clk);
    sweep_start[g] = 1'b1;
    @(negedge clk);
    sweep_start[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input int budget);
    int n;
    n = 0;
    while (fsm_state[g] != ST_IDLE && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("g%0d sweep_completes", g), {31'h0, fsm_state[g] == ST_IDLE}, 32'h1);
  endtask

  task automatic wait_state(input int g, input state_e s, input logic need_valid, input int budget);
    int n;
    n = 0;
    while (!(fsm_state[g] == s && (!need_valid || best_valid[g])) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("g%0d reach_state", g), {29'h0, fsm_state[g]}, {29'h0, s});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    for (int g = 0; g < 2; g++) begin
      sweep_start[g] = 1'b0;
      force_done[g]  = 1'b0;
      hang_en[g]     = 1'b0;
      hang_seed[g]   = 8'h00;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("g%0d rst best_z", g), best_z[g], 32'h7FFF_FFFF);
      check($sformatf("g%0d rst flags", g),
            {27'h0, best_valid[g], timeout_err[g], sweep_busy[g], core_start[g], core_rst_n[g]}, 32'h0);
    end
    check("g0 rst seed", {24'h0, a_init[0]}, 32'h00);
    check("g1 rst seed", {24'h0, a_init[1]}, 32'h7E);
    rst = 1'b0;

    // 1: seeds 0..3, z {5,2,3,2}: run 1 wins, tie with run 3 keeps run 1
    for (int i = 0; i < 4; i++) seed_q[0].push_back(8'(i));
    exp_q[0].push_back(exp_pack(32'h200, {8'h01, 8'h54, 8'hFE, 8'hFF}, 3'd1, 1'b1, 1'b0));
    pulse_start(0);
    wait_idle(0, 300);

    // 2: seed wrap 126,127,-128,-127; signed minimum at run 2
    seed_q[1].push_back(8'h7E);
    seed_q[1].push_back(8'h7F);
    seed_q[1].push_back(8'h80);
    seed_q[1].push_back(8'h81);
    exp_q[1].push_back(exp_pack(32'hFFFF_FF00, {8'h80, 8'hD5, 8'h7F, 8'h80}, 3'd2, 1'b1, 1'b0));
    pulse_start(1);
    wait_idle(1, 300);

    // 5: NUM_STARTS=0
    exp_q[2].push_back(exp_pack(32'h7FFF_FFFF, 32'h0, 3'd0, 1'b0, 1'b0));
    @(negedge clk);
    c_sweep_start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      c_sweep_start = 1'b0;
      if (c_done) pulses++;
    end
    check("zero done_pulses", pulses, 32'd1);
    check("zero state_idle", {29'h0, c_state}, {29'h0, ST_IDLE});

    // 3: run 2 never finishes -> timeout, sweep still completes
    hang_en[0]   = 1'b1;
    hang_seed[0] = 8'h02;
    for (int i = 0; i < 4; i++) seed_q[0].push_back(8'(i));
    exp_q[0].push_back(exp_pack(32'h200, {8'h01, 8'h54, 8'hFE, 8'hFF}, 3'd1, 1'b1, 1'b1));
    pulse_start(0);
    wait_idle(0, 300);
    hang_en[0] = 1'b0;

    // 6: core_done stuck high into WAIT_LOW plus sweep_start re-pulse while busy
    for (int i = 0; i < 4; i++) seed_q[0].push_back(8'(i));
    exp_q[0].push_back(exp_pack(32'h200, {8'h01, 8'h54, 8'hFE, 8'hFF}, 3'd1, 1'b1, 1'b0));
    pulse_start(0);
    wait_state(0, ST_CLEAR, 1'b0, 100);
    force_done[0] = 1'b1;
    repeat (3) @(negedge clk);
    sweep_start[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("g0 stall_wait_low", {29'h0, fsm_state[0]}, {29'h0, ST_WAIT_LOW});
      check("g0 stall_rst_n", {31'h0, core_rst_n[0]}, 32'h0);
      @(negedge clk);
      sweep_start[0] = 1'b0;
    end
    force_done[0] = 1'b0;
    @(negedge clk);
    sweep_start[0] = 1'b1;
    @(negedge clk);
    sweep_start[0] = 1'b0;
    wait_idle(0, 300);

    // 4: async reset in WAIT_DONE after a capture
    seed_q[0].push_back(8'h00);
    seed_q[0].push_back(8'h01);
    pulse_start(0);
    wait_state(0, ST_WAIT_DONE, 1'b1, 200);
    #2 rst = 1'b1;
    #1;
    check("g0 async_rst core_start", {31'h0, core_start[0]}, 32'h0);
    check("g0 async_rst core_rst_n", {31'h0, core_rst_n[0]}, 32'h0);
    check("g0 async_rst best_valid", {31'h0, best_valid[0]}, 32'h0);
    check("g0 async_rst busy", {31'h0, sweep_busy[0]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    repeat (20) @(negedge clk);
    for (int g = 0; g < 3; g++) check($sformatf("q%0d results_left", g), exp_q[g].size(), 32'd0);
    for (int g = 0; g < 2; g++) check($sformatf("q%0d seeds_left", g), seed_q[g].size(), 32'd0);
    check("zero core_start_seen", {31'h0, c_start_seen}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
